// File: rtl/iagc_sequencer_if.sv
// IAGC sequencer bus: control inputs from the run controller's host and
// processor stages, plus the status/gain outputs it publishes.
interface iagc_sequencer_if #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int QUOTIENT_SIZE    = 8,
    parameter int FRACTIONAL_SIZE  = 8
);
    logic                                     i_start;
    logic                                     i_abort;
    logic                                     i_inPhase;
    logic                                     i_ampUpdate;
    logic [QUOTIENT_SIZE-1:0]                 i_quotient;
    logic [FRACTIONAL_SIZE-1:0]               i_fractional;
    logic [IAGC_STATUS_SIZE-1:0]              o_iagcStatus;
    logic [QUOTIENT_SIZE+FRACTIONAL_SIZE-1:0] o_gain;
    logic                                     o_gainValid;
    logic                                     o_busy;
    logic                                     o_error;
    logic [1:0]                               o_retries;

    // Host / stimulus side
    modport master (
        output i_start, i_abort, i_inPhase, i_ampUpdate, i_quotient, i_fractional,
        input  o_iagcStatus, o_gain, o_gainValid, o_busy, o_error, o_retries
    );

    // Sequencer side
    modport slave (
        input  i_start, i_abort, i_inPhase, i_ampUpdate, i_quotient, i_fractional,
        output o_iagcStatus, o_gain, o_gainValid, o_busy, o_error, o_retries
    );
endinterface

// File: rtl/iagc_sequencer.sv
// IAGC run controller: phase lock -> amplitude capture -> division -> gain latch,
// with per-state timeouts, bounded retries and a registered status bus.
module iagc_sequencer #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int QUOTIENT_SIZE    = 8,
    parameter int FRACTIONAL_SIZE  = 8,
    parameter int PHASE_TIMEOUT    = 100000,
    parameter int AMP_TIMEOUT      = 100000,
    parameter int DIV_WAIT         = 4,
    parameter int MAX_RETRIES      = 3
) (
    input logic             i_clock,
    input logic             i_resetn,
    iagc_sequencer_if.slave bus
);
    localparam int CNT_W  = 17;
    localparam int GAIN_W = QUOTIENT_SIZE + FRACTIONAL_SIZE;

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] AMP_LAST   = CNT_W'(AMP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_WAIT - 1);
    localparam logic [7:0]       RETRY_MAX  = 8'(MAX_RETRIES);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PHASE = 4'd1,
        ST_AMP   = 4'd2,
        ST_DIV   = 4'd3,
        ST_DONE  = 4'd4,
        ST_ERROR = 4'd15
    } state_e;

    // Reset release synchroniser: assertion is immediate, release takes two edges.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    // Two-flop release of the external reset
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) rst_sync_q <= '0;
        else           rst_sync_q <= rst_sync_d;
    end

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [7:0]          retry_q,    retry_d;
    logic [GAIN_W-1:0]   gain_q,     gain_d;
    logic                gain_vld_q, gain_vld_d;
    logic                busy_q,     busy_d;
    logic                error_q,    error_d;
    logic                timeout;
    logic                restart;
    logic [CNT_W-1:0]    cnt_inc;

    // Counter saturates so it can never wrap while parked in IDLE/DONE/ERROR.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Next-state, counters and output values; abort overrides all state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        retry_d    = retry_q;
        gain_d     = gain_q;
        gain_vld_d = 1'b0;
        timeout    = 1'b0;
        restart    = 1'b0;

        if (bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.i_start) begin
                        state_d = ST_PHASE;
                        retry_d = '0;
                    end
                end
                ST_PHASE: begin
                    // Lock on the final cycle beats the timeout.
                    if (bus.i_inPhase)            state_d = ST_AMP;
                    else if (cnt_q == PHASE_LAST) timeout = 1'b1;
                end
                ST_AMP: begin
                    // Update on the final cycle beats the timeout; lock loss
                    // re-enters PHASE without consuming a retry.
                    if (bus.i_ampUpdate)        state_d = ST_DIV;
                    else if (!bus.i_inPhase)    state_d = ST_PHASE;
                    else if (cnt_q == AMP_LAST) timeout = 1'b1;
                end
                ST_DIV: begin
                    if (cnt_q == DIV_LAST) begin
                        state_d    = ST_DONE;
                        gain_d     = {bus.i_quotient, bus.i_fractional};
                        gain_vld_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (timeout) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_PHASE;
                restart = 1'b1;
            end else begin
                state_d = ST_ERROR;
            end
        end

        // A retry re-enters PHASE from PHASE, so it restarts the count too.
        if (state_d != state_q || restart) cnt_d = '0;

        busy_d  = (state_d == ST_PHASE) || (state_d == ST_AMP) || (state_d == ST_DIV);
        error_d = (state_d == ST_ERROR);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            gain_q     <= '0;
            gain_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            gain_q     <= gain_d;
            gain_vld_q <= gain_vld_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign bus.o_iagcStatus = IAGC_STATUS_SIZE'(state_q);
    assign bus.o_gain       = gain_q;
    assign bus.o_gainValid  = gain_vld_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_error      = error_q;
    assign bus.o_retries    = (retry_q > 8'd3) ? 2'd3 : retry_q[1:0];

endmodule
